// File: rtl/tri_bus_arbiter_if.sv
// Request/grant bundle between requesting blocks and the tri-state arbiter.
// master = requester side, slave = arbiter side.
interface tri_bus_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [N-1:0]  bus_oe;
  logic [IW-1:0] grant_id;
  logic          busy;

  modport master (output req, input grant, input bus_oe, input grant_id, input busy);
  modport slave  (input req, output grant, output bus_oe, output grant_id, output busy);
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner select for a shared tri-state net; bounded tenure, forced dead cycles between owners.
// Grant is registered one edge after req is sampled; requests are levels, nothing is queued.
module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 4,
  parameter int TURN_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  tri_bus_arbiter_if.slave   bus
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
  localparam logic [TW-1:0] TURN_LIM = TW'(TURN_CYC);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;

  logic          req_hit;
  logic [IW-1:0] win;
  logic [IW-1:0] scan_idx;
  logic          hold_ok;
  logic          turn_last;
  logic          take;

  // First requester at or after ptr, wrapping mod N.
  always_comb begin
    req_hit  = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % N);
      if (!req_hit && bus.req[scan_idx]) begin
        req_hit = 1'b1;
        win     = scan_idx;
      end
    end
  end

  assign hold_ok   = bus.req[gid_q] && (hold_q < HOLD_LIM);
  assign turn_last = (turn_q >= TURN_LIM);
  assign take      = req_hit && ((state_q == IDLE) || ((state_q == TURN) && turn_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hit) state_d = GRANT;
      GRANT:   if (!hold_ok) state_d = TURN;
      TURN:    if (turn_last) state_d = req_hit ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    if (take) begin
      grant_d = {{(N-1){1'b0}}, 1'b1} << win;
      gid_d   = win;
      hold_d  = HW'(1);
      turn_d  = '0;
      ptr_d   = (win == IW'(N - 1)) ? '0 : win + 1'b1;
    end else begin
      case (state_q)
        GRANT: begin
          if (hold_ok) begin
            hold_d = hold_q + 1'b1;
          end else begin
            grant_d = '0;
            hold_d  = '0;
            turn_d  = TW'(1);
          end
        end
        TURN:    turn_d = turn_last ? '0 : turn_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Enables follow the grant register directly so the net never sees a req-to-driver path.
  assign bus.grant    = grant_q;
  assign bus.bus_oe   = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed and random stimulus for tri_bus_arbiter against a cycle-level ownership model.
module tb_tri_bus_arbiter;
  localparam int N        = 4;
  localparam int HOLD_MAX = 4;
  localparam int TURN_CYC = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tri_bus_arbiter_if #(.N(N)) bus ();

  tri_bus_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX), .TURN_CYC(TURN_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference: who owns the net, how long, how many dead cycles have elapsed.
  int m_owner, m_ten, m_gap, m_ptr, m_last;

  task automatic model_reset();
    m_owner = -1; m_ten = 0; m_gap = 0; m_ptr = 0; m_last = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    if (m_owner >= 0) begin
      if (r[m_owner] && m_ten < HOLD_MAX) m_ten++;
      else begin m_owner = -1; m_gap = 1; end
    end else if (m_gap > 0 && m_gap < TURN_CYC) begin
      m_gap++;
    end else begin
      m_gap = 0;
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      if (m_owner >= 0) begin
        m_ten  = 1;
        m_last = m_owner;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk({tag, "_grant"},  32'(bus.grant),    eg);
    chk({tag, "_bus_oe"}, 32'(bus.bus_oe),   eg);
    chk({tag, "_gid"},    32'(bus.grant_id), 32'(m_last));
    chk({tag, "_busy"},   32'(bus.busy),     32'((m_owner >= 0) || (m_gap > 0)));
    chk({tag, "_1hot"},   32'($onehot0(bus.bus_oe)), 32'd1);
  endtask

  // Called at posedge+1; req is stable until the next posedge.
  task automatic cyc(input logic [N-1:0] r, input string tag);
    bus.req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rr;

  initial begin
    rst_n   = 1'b0;
    bus.req = '1;
    model_reset();

    // 1: reset holds everything quiet even with all requests up
    #2;
    check_outputs("t1_rst");
    chk("t1_rst_oe", 32'(bus.bus_oe), 32'h0);
    @(posedge clk);
    #1;
    check_outputs("t1_rst_edge");
    #2;
    rst_n = 1'b1;
    cyc(4'b1111, "t1");
    chk("t1_first", 32'(bus.grant), 32'h1);

    // 2: lone requester, period HOLD_MAX + TURN_CYC
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(4'b0100, "t2");
      chk("t2_pat", 32'(bus.grant), ((i % 5) < 4) ? 32'h4 : 32'h0);
    end

    // 3: full load rotates through every requester and wraps
    do_reset();
    for (int i = 0; i < 21; i++) begin
      cyc(4'b1111, "t3");
      chk("t3_pat", 32'(bus.grant), ((i % 5) < 4) ? (32'd1 << ((i / 5) % 4)) : 32'h0);
    end

    // 4: early release
    do_reset();
    cyc(4'b0010, "t4a"); chk("t4_g1", 32'(bus.grant), 32'h2);
    cyc(4'b0010, "t4b"); chk("t4_g2", 32'(bus.grant), 32'h2);
    cyc(4'b0000, "t4c"); chk("t4_turn", 32'(bus.grant), 32'h0); chk("t4_turn_busy", 32'(bus.busy), 32'h1);
    cyc(4'b0000, "t4d"); chk("t4_idle_busy", 32'(bus.busy), 32'h0);

    // 5: async reset mid-tenure
    do_reset();
    cyc(4'b1000, "t5a");
    cyc(4'b1000, "t5b");
    chk("t5_pre", 32'(bus.bus_oe), 32'h8);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_async_oe", 32'(bus.bus_oe), 32'h0);
    check_outputs("t5_rst");
    #2;
    rst_n = 1'b1;
    cyc(4'b1010, "t5c");
    chk("t5_after", 32'(bus.grant), 32'h2);

    // 6: owner 3 times out, wrap picks 0 ahead of 3
    do_reset();
    for (int i = 0; i < 5; i++) cyc(4'b1000, "t6a");
    chk("t6_turn", 32'(bus.grant), 32'h0);
    cyc(4'b1001, "t6b");
    chk("t6_wrap", 32'(bus.grant), 32'h1);
    chk("t6_gid", 32'(bus.grant_id), 32'h0);
    for (int i = 0; i < 4; i++) cyc(4'b1111, "t6c");
    cyc(4'b1111, "t6d");
    chk("t6_ptr1", 32'(bus.grant), 32'h2);

    // random traffic with one reset in the middle
    do_reset();
    rr = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rr = N'($urandom_range(0, (1 << N) - 1));
      if (i == 200) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rnd_rst");
        rst_n = 1'b1;
      end
      cyc(rr, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
